// File: rtl/matrix_add_sequencer.sv
// Front-end sequencer for the matrix-add unit: loads A and B element by element,
// runs the combinational adder for one cycle, then streams the result back out.
module matrix_add_sequencer #(
    parameter int ELEM_W    = 8,
    parameter int MAX_ELEMS = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    matrix_size,
    input  logic [ELEM_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ELEM_W*MAX_ELEMS-1:0]   adder_matrix_A,
    output logic [ELEM_W*MAX_ELEMS-1:0]   adder_matrix_B,
    output logic [1:0]                    adder_matrix_size,
    input  logic [ELEM_W*MAX_ELEMS-1:0]   adder_result,
    input  logic                          adder_overflow,
    output logic [ELEM_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int MW = ELEM_W * MAX_ELEMS;
    localparam int CW = $clog2(MAX_ELEMS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] a_q, a_d;
    logic [MW-1:0] b_q, b_d;
    logic [MW-1:0] res_q, res_d;
    logic [1:0]    size_q, size_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] last_idx;

    always_comb begin
        case (size_q)
            2'b00:   last_idx = CW'(3);
            2'b01:   last_idx = CW'(8);
            2'b10:   last_idx = CW'(15);
            default: last_idx = CW'(24);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d  = matrix_size;
                    a_d     = '0;
                    b_d     = '0;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    a_d[cnt_q*ELEM_W +: ELEM_W] = in_data;
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (in_valid) begin
                    b_d[cnt_q*ELEM_W +: ELEM_W] = in_data;
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EXEC: begin
                res_d   = adder_result;
                ovf_d   = adder_overflow;
                cnt_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
        end
    end

    // All handshake/status outputs decode from the registered state only.
    assign in_ready          = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign out_valid         = (state_q == S_DRAIN);
    assign out_data          = (state_q == S_DRAIN) ? res_q[cnt_q*ELEM_W +: ELEM_W] : '0;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign overflow          = ovf_q;
    assign adder_matrix_A    = a_q;
    assign adder_matrix_B    = b_q;
    assign adder_matrix_size = size_q;

endmodule

// File: doc/matrix_add_sequencer.md
Name: matrix_add_sequencer

Overview:
- Front-end controller for the matrix-add unit of the HPS-to-FPGA coprocessor.
- Accepts a start command with a matrix size, then streams in the elements of A and B one 8-bit element per handshake into internal 200-bit registers.
- Drives the combinational adder and captures its saturated result and overflow flag in one cycle.
- Streams the result back out element by element with valid/ready backpressure.

Parameters:
- ELEM_W, 8: element width in bits; fixed to match the adder packing.
- MAX_ELEMS, 25: capacity of the packed matrix registers (5x5).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  command pulse; sampled only in IDLE
- matrix_size  input  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; latched on accepted start
- in_data  input  8  element of A or B
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts in_data
- adder_matrix_A  output  200  packed A to the adder; element i at bits [i*8+:8]
- adder_matrix_B  output  200  packed B to the adder
- adder_matrix_size  output  2  latched size to the adder
- adder_result  input  200  adder result, combinational from the adder inputs
- adder_overflow  input  1  adder overflow flag
- out_data  output  8  result element
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at operation end
- overflow  output  1  captured overflow of the last operation

Behaviour:
- Reset, synchronous and active-high, dominates all other inputs. It forces:
  - state IDLE and element counter 0
  - A, B and result registers all zero; latched size 00
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0, overflow=0
- Reset asserted mid-operation abandons the operation immediately. No done pulse is produced.
- N = 4/9/16/25 for size 00/01/10/11. Elements use linear row-major index 0..N-1.
- IDLE:
  - in_ready=0, out_valid=0.
  - If start=1: latch matrix_size, zero the A, B and result registers, clear overflow, counter=0, go to LOAD_A.
  - in_valid in the same cycle as start is not consumed.
- LOAD_A:
  - in_ready=1.
  - On in_valid&in_ready: A[cnt*8+:8] <= in_data and cnt++.
  - On the beat with cnt==N-1: cnt=0, go to LOAD_B.
  - Cycles with in_valid=0 stall without any state change.
- LOAD_B:
  - Same handshake as LOAD_A, writing into B.
  - After the beat with cnt==N-1: cnt=0, go to EXEC.
- EXEC, exactly one cycle:
  - in_ready=0.
  - result_reg <= adder_result, overflow <= adder_overflow.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=result_reg[cnt*8+:8].
  - On out_valid&out_ready: cnt++.
  - After the beat with cnt==N-1: go to DONE.
  - While out_ready=0, out_data and out_valid hold stable.
- DONE, one cycle: done=1, out_valid=0, then go to IDLE.
- overflow holds its value until the next accepted start or reset.
- start outside IDLE is ignored, including start in the DONE cycle.
- Elements at index N..24 stay zero in A and B; the adder also zeroes them.
- Latency with no stalls: start at cycle 0 gives LOAD_A at 1..N, LOAD_B at N+1..2N, EXEC at 2N+1, DRAIN at 2N+2..3N+1, done at 3N+2.
- The adder outputs (adder_matrix_A, adder_matrix_B, adder_matrix_size) are driven directly from the registers.

Test Plan:
- 2x2, no stalls:
  - Stimulus: A={1,2,3,4}, B={10,20,30,40}.
  - Required: out_data 11,22,33,44 on cycles 10..13; done at cycle 14; overflow=0; busy high on cycles 1..14.
- 5x5 saturation:
  - Stimulus: A[0]=100, B[0]=100, A[24]=-100 (0x9C), B[24]=-100, all other elements 0.
  - Required: out element 0 = 0x7F, out element 24 = 0x80, all others 0; overflow=1, and it stays 1 after done until the next start.
- Backpressure:
  - Stimulus: 3x3 operation; out_ready held low for 5 cycles on element 4, and in_valid gaps inserted during LOAD_B.
  - Required: out_data for element 4 stays stable throughout the stall; all 9 results are correct and in order; no element lost or duplicated.
- Reset mid-load:
  - Stimulus: 4x4 operation; reset asserted after 7 A beats; then a fresh 2x2 operation.
  - Required: every output returns to reset values the next cycle with no done pulse; the 2x2 operation yields correct results with no stale A data.
- Ignored start:
  - Stimulus: start pulses with matrix_size=11 during LOAD_B and during DRAIN of a 2x2 operation.
  - Required: the operation still completes with N=4 elements; adder_matrix_size stays 00.
- start together with in_valid:
  - Stimulus: start=1 and in_valid=1 in the same IDLE cycle.
  - Required: that in_data is not written; the first A element is taken in the next cycle.
